// File: rtl/input_debounce.sv
// Two-flop synchroniser plus per-channel stable-count debouncer.
// Emits clean levels, one-cycle rise/fall pulses and a settled flag.
module input_debounce #(
   parameter int unsigned      WIDTH           = 4,
   parameter int unsigned      DEBOUNCE_CYCLES = 1_000_000,
   parameter logic [WIDTH-1:0] RESET_VAL       = '0
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_raw,
   output logic [WIDTH-1:0] o_level,
   output logic [WIDTH-1:0] o_rise,
   output logic [WIDTH-1:0] o_fall,
   output logic             o_settled
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] s1_q;
   logic [WIDTH-1:0] s2_q;
   logic [WIDTH-1:0] level_q;
   logic [WIDTH-1:0] level_d;
   logic [WIDTH-1:0] rise_q;
   logic [WIDTH-1:0] rise_d;
   logic [WIDTH-1:0] fall_q;
   logic [WIDTH-1:0] fall_d;
   logic [CW-1:0]    cnt_q [WIDTH];
   logic [CW-1:0]    cnt_d [WIDTH];
   logic             settled_q;
   logic             settled_d;

   always_comb begin
      level_d   = level_q;
      rise_d    = '0;
      fall_d    = '0;
      settled_d = (s2_q == level_q);
      for (int k = 0; k < int'(WIDTH); k++) begin
         cnt_d[k] = '0;
         if (cnt_q[k] != '0) settled_d = 1'b0;
         if (s2_q[k] != level_q[k]) begin
            if (cnt_q[k] == LAST) begin
               // Accept: level and its pulse update on the same edge
               level_d[k] = s2_q[k];
               rise_d[k]  = s2_q[k];
               fall_d[k]  = ~s2_q[k];
            end else begin
               cnt_d[k] = cnt_q[k] + CW'(1);
            end
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         s1_q      <= RESET_VAL;
         s2_q      <= RESET_VAL;
         level_q   <= RESET_VAL;
         rise_q    <= '0;
         fall_q    <= '0;
         settled_q <= 1'b1;
         for (int k = 0; k < int'(WIDTH); k++) cnt_q[k] <= '0;
      end else begin
         s1_q      <= i_raw;
         s2_q      <= s1_q;
         level_q   <= level_d;
         rise_q    <= rise_d;
         fall_q    <= fall_d;
         settled_q <= settled_d;
         for (int k = 0; k < int'(WIDTH); k++) cnt_q[k] <= cnt_d[k];
      end
   end

   assign o_level   = level_q;
   assign o_rise    = rise_q;
   assign o_fall    = fall_q;
   assign o_settled = settled_q;

endmodule

// File: tb/tb_input_debounce.sv
// Directed scoreboard bench for input_debounce.
// Instance 0 uses DEBOUNCE_CYCLES=4, instance 1 uses DEBOUNCE_CYCLES=1.
module tb_input_debounce;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] raw0 = 4'b0000;
   logic [3:0] raw1 = 4'b0000;
   logic [3:0] lvl0, rise0, fall0;
   logic [3:0] lvl1, rise1, fall1;
   logic       set0, set1;

   int checks = 0;
   int failures = 0;

   typedef struct {
      string      tag;
      bit         dut;
      logic [3:0] lvl;
      logic [3:0] rise;
      logic [3:0] fall;
      bit         chk_s;
      logic       s;
   } exp_t;

   exp_t sbq[$];

   always #5 clk = ~clk;

   input_debounce #(.WIDTH(4), .DEBOUNCE_CYCLES(4)) dut0 (
      .i_clk(clk), .i_rst(rst), .i_raw(raw0),
      .o_level(lvl0), .o_rise(rise0), .o_fall(fall0), .o_settled(set0)
   );

   input_debounce #(.WIDTH(4), .DEBOUNCE_CYCLES(1)) dut1 (
      .i_clk(clk), .i_rst(rst), .i_raw(raw1),
      .o_level(lvl1), .o_rise(rise1), .o_fall(fall1), .o_settled(set1)
   );

   task automatic push(input string tag, input bit dut,
                       input logic [3:0] lvl, input logic [3:0] rise,
                       input logic [3:0] fall, input bit chk_s,
                       input logic s);
      exp_t e;
      e.tag = tag; e.dut = dut; e.lvl = lvl; e.rise = rise;
      e.fall = fall; e.chk_s = chk_s; e.s = s;
      sbq.push_back(e);
   endtask

   task automatic check_one();
      exp_t e;
      logic [11:0] obs;
      logic [11:0] exp_v;
      logic        obs_s;
      if (sbq.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL sb_empty observed=0 expected=entry");
         return;
      end
      e = sbq.pop_front();
      obs   = e.dut ? {lvl1, rise1, fall1} : {lvl0, rise0, fall0};
      obs_s = e.dut ? set1 : set0;
      exp_v = {e.lvl, e.rise, e.fall};
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s lvl/rise/fall observed=%b expected=%b",
                e.tag, obs, exp_v);
      end
      if (e.chk_s) begin
         checks++;
         assert (obs_s === e.s) else begin
            failures++;
            $error("FAIL %s settled observed=%b expected=%b",
                   e.tag, obs_s, e.s);
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      check_one();
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Level changes on edge n; pulse only on that edge; settled after it.
   task automatic expect_accept(input string tag, input bit dut,
                                input int n, input logic [3:0] old_v,
                                input logic [3:0] new_v);
      for (int i = 1; i < n; i++) push(tag, dut, old_v, 4'b0, 4'b0, 0, 1'b0);
      push(tag, dut, new_v, new_v & ~old_v, old_v & ~new_v, 1, 1'b0);
      push(tag, dut, new_v, 4'b0, 4'b0, 1, 1'b1);
   endtask

   task automatic accept(input string tag, input bit dut, input int n,
                         input logic [3:0] old_v, input logic [3:0] new_v);
      expect_accept(tag, dut, n, old_v, new_v);
      steps(n + 1);
   endtask

   initial begin
      logic [7:0] sp;
      logic [5:0] bounce;

      // Reset with a non-reset raw value waiting on the pins
      rst  = 1'b1;
      raw0 = 4'b1010;
      repeat (2) @(posedge clk);
      #1;
      push("rst_d0", 0, 4'b0000, 4'b0, 4'b0, 1, 1'b1);
      check_one();
      push("rst_d1", 1, 4'b0000, 4'b0, 4'b0, 1, 1'b1);
      check_one();
      rst = 1'b0;
      accept("t1_release", 0, 6, 4'b0000, 4'b1010);

      // 3-cycle glitch on bit 0 is rejected; settled dips then recovers
      sp = 8'b1100_0011;
      for (int i = 0; i < 8; i++)
         push("t2_glitch", 0, 4'b1010, 4'b0, 4'b0, 1, sp[i]);
      raw0 = 4'b1011;
      steps(3);
      raw0 = 4'b1010;
      steps(5);

      // Bit 2 rise then fall
      raw0 = 4'b1110;
      accept("t3_rise", 0, 6, 4'b1010, 4'b1110);
      raw0 = 4'b1010;
      accept("t3_fall", 0, 6, 4'b1110, 4'b1010);

      // Bring bit 1 low, then bounce it up
      raw0 = 4'b1000;
      accept("t4_pre", 0, 6, 4'b1010, 4'b1000);
      bounce = 6'b101101;
      expect_accept("t4_bounce", 0, 11, 4'b1000, 4'b1010);
      for (int i = 0; i < 6; i++) begin
         raw0[1] = bounce[i];
         step();
      end
      steps(6);

      // Reset in the middle of a pending change on bit 3
      raw0 = 4'b0010;
      for (int i = 0; i < 4; i++)
         push("t5_pend", 0, 4'b1010, 4'b0, 4'b0, 0, 1'b0);
      steps(4);
      rst = 1'b1;
      #1;
      push("t5_rst", 0, 4'b0000, 4'b0, 4'b0, 1, 1'b1);
      check_one();
      push("t5_rst_hold", 0, 4'b0000, 4'b0, 4'b0, 1, 1'b1);
      step();
      rst = 1'b0;
      accept("t5_reaccept", 0, 6, 4'b0000, 4'b0010);

      // Minimum debounce: all four bits together
      raw1 = 4'b1111;
      accept("t6_rise", 1, 3, 4'b0000, 4'b1111);
      raw1 = 4'b0000;
      accept("t6_fall", 1, 3, 4'b1111, 4'b0000);

      checks++;
      assert (sbq.size() == 0) else begin
         failures++;
         $error("FAIL sb_leftover observed=%0d expected=0", sbq.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
